gen_origin_axis_mf: RTL and testbench

//  Parametrised multi-frame AXI-stream origin (pattern) generator for bring-up and BIST paths.
//  - Emits a programmable number of frames with a programmable beat length and inter-frame gap.
//  - Payload pattern is selected at build time: RANGE, FIXED or LFSR.
//  - Feeds any axis sink directly; it is the source end of a test chain.

---
 rtl/gen_origin_axis_mf_pkg.sv | 18 +
 rtl/gen_origin_axis_mf_if.sv | 14 +
 rtl/gen_origin_axis_mf_pattern.sv | 53 +++++
 rtl/gen_origin_axis_mf.sv | 210 +++++++++++++++++++++
 tb/tb_gen_origin_axis_mf.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_origin_axis_mf_pkg.sv
// Shared types and constants for the multi-frame axis origin generator.
// Holds the FSM encoding, payload mode tags and the LFSR step function.
package gen_origin_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} gen_state_t;

  // Galois form of x^32 + x^22 + x^2 + x + 1, right-shifting.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [39:0] MODE_RANGE = "RANGE";
  localparam logic [39:0] MODE_FIXED = "FIXED";
  localparam logic [39:0] MODE_LFSR  = {8'h00, "LFSR"};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/gen_origin_axis_mf_if.sv
// AXI-stream bundle between the generator (master) and its sink (slave).
interface gen_origin_axis_mf_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tuser;

  modport master (output tdata, tvalid, tlast, tkeep, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/gen_origin_axis_mf_pattern.sv
// Payload register: loads the frame start word, advances one step per accepted beat.
// No latency beyond the register; holds its value whenever adv_i/load_i are low.
module gen_origin_pattern
  import gen_origin_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [39:0] MODE       = MODE_RANGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [DATA_WIDTH-1:0] start_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [31:0]           seed;

  always_comb begin
    data_d = data_q;
    lfsr_d = lfsr_q;
    seed   = 32'(start_i);
    if (load_i) begin
      data_d = start_i;
      // an all-zero state would lock the LFSR up
      lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (adv_i) begin
      if (MODE != MODE_FIXED) data_d = data_q + step_i;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      lfsr_q <= '0;
    end else begin
      data_q <= data_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    data_o = data_q;
    if (MODE == MODE_LFSR) begin
      for (int i = 0; i < DATA_WIDTH; i++) data_o[i] = lfsr_q[i[4:0]];
    end
  end

endmodule

// File: rtl/gen_origin_axis_mf.sv
// Multi-frame axis pattern source: first beat one cycle after accept, holds beats under tready stalls.
// Define GEN_ORIGIN_AXIS_STAT_EN to add saturating beat/stall counters.
module gen_origin_axis_mf
  import gen_origin_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [39:0] MODE       = MODE_RANGE,
  parameter int          LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aclken_i,
  input  logic                  enable_i,
  input  logic                  abort_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [DATA_WIDTH-1:0] start_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic [15:0]           frames_i,
  input  logic [15:0]           gap_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
`ifdef GEN_ORIGIN_AXIS_STAT_EN
  output logic [31:0]           stat_beats_o,
  output logic [31:0]           stat_stalls_o,
`endif
  gen_origin_axis_mf_if.master  axis
);

  gen_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, beat_q, beat_d;
  logic [15:0]           frames_q, frames_d, frame_cnt_q, frame_cnt_d;
  logic [15:0]           gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] start_q, start_d, step_q, step_d, pat_dat;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                  ready_q, ready_d, frame_done_q, frame_done_d, abort_q, abort_d;
  logic                  accept, hs, abort_now, done;

  always_comb begin
    accept    = enable_i && ready_q && aclken_i;
    hs        = tvalid_q && axis.tready && aclken_i;
    abort_now = abort_q || (abort_i && state_q != IDLE);
    done      = abort_now || (frames_q != 16'd0 && frame_cnt_q + 16'd1 == frames_q);

    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    frames_d     = frames_q;
    frame_cnt_d  = frame_cnt_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    start_d      = start_q;
    step_d       = step_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    frame_done_d = 1'b0;
    abort_d      = abort_now;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          state_d     = SEND;
          len_d       = (length_i == '0) ? LEN_WIDTH'(1) : length_i;
          start_d     = start_i;
          step_d      = step_i;
          frames_d    = frames_i;
          gap_d       = gap_i;
          beat_d      = '0;
          frame_cnt_d = '0;
          tvalid_d    = 1'b1;
          tuser_d     = 1'b1;
          tlast_d     = (length_i <= LEN_WIDTH'(1));
        end
      end
      SEND: begin
        if (hs && tlast_q) begin
          frame_done_d = 1'b1;
          beat_d       = '0;
          tuser_d      = 1'b0;
          tlast_d      = 1'b0;
          if (done) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            abort_d  = 1'b0;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (gap_q != 16'd0) begin
              state_d   = GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q;
            end else begin
              tuser_d = 1'b1;
              tlast_d = (len_q == LEN_WIDTH'(1));
            end
          end
        end else if (hs) begin
          beat_d  = beat_q + LEN_WIDTH'(1);
          tuser_d = 1'b0;
          tlast_d = (beat_q + LEN_WIDTH'(2) == len_q);
        end
      end
      GAP: begin
        // an abort landing in the gap means the last frame is already complete
        if (abort_now) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end else if (gap_cnt_q == 16'd1) begin
          state_d   = SEND;
          gap_cnt_d = '0;
          tvalid_d  = 1'b1;
          tuser_d   = 1'b1;
          tlast_d   = (len_q == LEN_WIDTH'(1));
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      frames_q     <= '0;
      frame_cnt_q  <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      start_q      <= '0;
      step_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else if (aclken_i) begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      frames_q     <= frames_d;
      frame_cnt_q  <= frame_cnt_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      start_q      <= start_d;
      step_q       <= step_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  // pattern restarts on the last beat so the next frame opens with the start word
  gen_origin_pattern #(.DATA_WIDTH(DATA_WIDTH), .MODE(MODE)) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept || (hs && tlast_q)),
    .adv_i   (hs && !tlast_q),
    .start_i (accept ? start_i : start_q),
    .step_i  (step_q),
    .data_o  (pat_dat)
  );

`ifdef GEN_ORIGIN_AXIS_STAT_EN
  logic [31:0] beats_q, beats_d, stalls_q, stalls_d;

  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (accept) begin
      beats_d  = '0;
      stalls_d = '0;
    end else begin
      if (hs && beats_q != '1) beats_d = beats_q + 32'd1;
      if (tvalid_q && !axis.tready && aclken_i && stalls_q != '1) stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_beats_o  = beats_q;
  assign stat_stalls_o = stalls_q;
`endif

  assign axis.tdata   = pat_dat;
  assign axis.tvalid  = tvalid_q;
  assign axis.tlast   = tlast_q;
  assign axis.tuser   = tuser_q;
  assign axis.tkeep   = '1;
  assign ready_o      = ready_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_gen_origin_axis_mf.sv
// Directed bench for gen_origin_axis_mf: a RANGE instance for framing/flow control, an LFSR one for seeding.
module tb_gen_origin_axis_mf;
  import gen_origin_pkg::*;

  logic        clk, rst, aclken, enable, enable_l, abort;
  logic [31:0] length, start, step;
  logic [15:0] frames, gap;
  logic        ready, busy, fdone, ready_l, busy_l, fdone_l;
  int          n_cmp, n_err;
`ifdef GEN_ORIGIN_AXIS_STAT_EN
  logic [31:0] sb, ss, sb_l, ss_l;
`endif

  gen_origin_axis_mf_if #(.DATA_WIDTH(32)) ax ();
  gen_origin_axis_mf_if #(.DATA_WIDTH(32)) axl ();

  gen_origin_axis_mf #(.DATA_WIDTH(32), .MODE(MODE_RANGE), .LEN_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .aclken_i(aclken), .enable_i(enable), .abort_i(abort),
    .length_i(length), .start_i(start), .step_i(step), .frames_i(frames), .gap_i(gap),
    .ready_o(ready), .busy_o(busy), .frame_done_o(fdone),
`ifdef GEN_ORIGIN_AXIS_STAT_EN
    .stat_beats_o(sb), .stat_stalls_o(ss),
`endif
    .axis(ax)
  );

  gen_origin_axis_mf #(.DATA_WIDTH(32), .MODE(MODE_LFSR), .LEN_WIDTH(32)) dut_l (
    .clk(clk), .rst(rst), .aclken_i(aclken), .enable_i(enable_l), .abort_i(abort),
    .length_i(length), .start_i(start), .step_i(step), .frames_i(frames), .gap_i(gap),
    .ready_o(ready_l), .busy_o(busy_l), .frame_done_o(fdone_l),
`ifdef GEN_ORIGIN_AXIS_STAT_EN
    .stat_beats_o(sb_l), .stat_stalls_o(ss_l),
`endif
    .axis(axl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] l, input logic [31:0] s, input logic [31:0] st,
                             input logic [15:0] f, input logic [15:0] g);
    length = l; start = s; step = st; frames = f; gap = g;
    enable = 1'b1;
    tick;
    enable = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ax.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", ax.tvalid); end
    n_cmp++; if (ax.tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", ax.tdata); end
    n_cmp++; if ({ax.tlast, ax.tuser, fdone} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {ax.tlast, ax.tuser, fdone}); end
    n_cmp++; if (ax.tkeep !== 4'hF) begin n_err++; $display("FAIL reset_tkeep: got %h want f", ax.tkeep); end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b want 1", ready); end
  endtask

  task automatic test_range_gaps;
    logic        ev[12] = '{1,1,1,1,0,0,0,1,1,1,1,0};
    logic [31:0] ed[12] = '{10,12,14,16,0,0,0,10,12,14,16,0};
    logic        el[12] = '{0,0,0,1,0,0,0,0,0,0,1,0};
    logic        eu[12] = '{1,0,0,0,0,0,0,1,0,0,0,0};
    start_frame(32'd4, 32'd10, 32'd2, 16'd2, 16'd3);
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (ax.tvalid !== ev[i]) begin n_err++; $display("FAIL gaps_tvalid[%0d]: got %b want %b", i, ax.tvalid, ev[i]); end
      if (ev[i]) begin
        n_cmp++; if (ax.tdata !== ed[i]) begin n_err++; $display("FAIL gaps_tdata[%0d]: got %0d want %0d", i, ax.tdata, ed[i]); end
        n_cmp++; if ({ax.tlast, ax.tuser} !== {el[i], eu[i]}) begin n_err++; $display("FAIL gaps_last_user[%0d]: got %b%b want %b%b", i, ax.tlast, ax.tuser, el[i], eu[i]); end
      end
      if (i == 4 || i == 11) begin
        n_cmp++; if (fdone !== 1'b1) begin n_err++; $display("FAIL gaps_frame_done[%0d]: got %b want 1", i, fdone); end
      end
      if (i == 11) begin
        n_cmp++; if ({ready, busy} !== 2'b10) begin n_err++; $display("FAIL gaps_idle: ready/busy got %b%b want 10", ready, busy); end
      end
      tick;
    end
  endtask

  task automatic test_single;
    for (int l = 0; l < 2; l++) begin
      start_frame(32'(l), 32'h55 + 32'(l), 32'd1, 16'd1, 16'd0);
      n_cmp++; if ({ax.tvalid, ax.tlast, ax.tuser} !== 3'b111) begin n_err++; $display("FAIL single_flags len=%0d: got %b want 111", l, {ax.tvalid, ax.tlast, ax.tuser}); end
      n_cmp++; if (ax.tdata !== 32'h55 + 32'(l)) begin n_err++; $display("FAIL single_tdata len=%0d: got %h want %h", l, ax.tdata, 32'h55 + 32'(l)); end
      tick;
      n_cmp++; if ({fdone, ax.tvalid, ready} !== 3'b101) begin n_err++; $display("FAIL single_done len=%0d: done/tvalid/ready got %b want 101", l, {fdone, ax.tvalid, ready}); end
      tick;
      n_cmp++; if (fdone !== 1'b0) begin n_err++; $display("FAIL single_pulse len=%0d: got %b want 0", l, fdone); end
    end
  endtask

  task automatic test_stall;
    int          k, stalls;
    logic        r, prev_v, prev_r, prev_l;
    logic [31:0] prev_d;
    k = 0; stalls = 0; prev_v = 1'b0; prev_r = 1'b1; prev_l = 1'b0; prev_d = '0;
    start_frame(32'd8, 32'd100, 32'd1, 16'd1, 16'd5);
    start = 32'd999;
    step  = 32'd7;
    for (int c = 0; c < 300 && busy; c++) begin
      r = 1'($urandom_range(0, 1));
      ax.tready = r;
      n_cmp++; if (ax.tvalid !== 1'b1) begin n_err++; $display("FAIL stall_bubble c=%0d: tvalid got %b want 1", c, ax.tvalid); end
      if (prev_v && !prev_r) begin
        n_cmp++; if ({ax.tdata, ax.tlast} !== {prev_d, prev_l}) begin n_err++; $display("FAIL stall_hold c=%0d: got %h/%b want %h/%b", c, ax.tdata, ax.tlast, prev_d, prev_l); end
      end
      if (ax.tvalid && r) begin
        n_cmp++; if (ax.tdata !== 32'd100 + 32'(k)) begin n_err++; $display("FAIL stall_tdata beat %0d: got %0d want %0d", k, ax.tdata, 100 + k); end
        n_cmp++; if (ax.tlast !== (k == 7)) begin n_err++; $display("FAIL stall_tlast beat %0d: got %b want %b", k, ax.tlast, k == 7); end
        k++;
      end else if (ax.tvalid) begin
        stalls++;
      end
      prev_v = ax.tvalid; prev_r = r; prev_d = ax.tdata; prev_l = ax.tlast;
      tick;
    end
    ax.tready = 1'b1;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL stall_beats: got %0d want 8", k); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_timeout: busy got %b want 0", busy); end
`ifdef GEN_ORIGIN_AXIS_STAT_EN
    n_cmp++; if (sb !== 32'd8) begin n_err++; $display("FAIL stat_beats: got %0d want 8", sb); end
    n_cmp++; if (ss !== 32'(stalls)) begin n_err++; $display("FAIL stat_stalls: got %0d want %0d", ss, stalls); end
`endif
  endtask

  task automatic test_abort_cont;
    logic [31:0] ed[9] = '{0,1,2,0,1,2,0,1,2};
    logic        el[9] = '{0,0,1,0,0,1,0,0,1};
    logic        eu[9] = '{1,0,0,1,0,0,1,0,0};
    start_frame(32'd3, 32'd0, 32'd1, 16'd0, 16'd0);
    for (int i = 0; i < 11; i++) begin
      abort = (i == 7);
      if (i < 9) begin
        n_cmp++; if (ax.tvalid !== 1'b1) begin n_err++; $display("FAIL cont_tvalid[%0d]: got %b want 1", i, ax.tvalid); end
        n_cmp++; if ({ax.tdata, ax.tlast, ax.tuser} !== {ed[i], el[i], eu[i]}) begin n_err++; $display("FAIL cont_beat[%0d]: got %0d/%b/%b want %0d/%b/%b", i, ax.tdata, ax.tlast, ax.tuser, ed[i], el[i], eu[i]); end
      end else begin
        n_cmp++; if ({ax.tvalid, ready} !== 2'b01) begin n_err++; $display("FAIL cont_stop[%0d]: tvalid/ready got %b want 01", i, {ax.tvalid, ready}); end
      end
      tick;
    end
    abort = 1'b0;
  endtask

  task automatic test_wrap;
    logic [31:0] ed[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    start_frame(32'd4, 32'hFFFF_FFFE, 32'd1, 16'd1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({ax.tvalid, ax.tdata, ax.tlast} !== {1'b1, ed[i], i == 3}) begin n_err++; $display("FAIL wrap[%0d]: got %b/%h/%b want 1/%h/%b", i, ax.tvalid, ax.tdata, ax.tlast, ed[i], i == 3); end
      tick;
    end
  endtask

  task automatic test_lfsr;
    length = 32'd2; start = 32'd0; step = 32'd1; frames = 16'd1; gap = 16'd0;
    enable_l = 1'b1;
    tick;
    enable_l = 1'b0;
    n_cmp++; if ({axl.tvalid, axl.tuser, axl.tdata} !== {2'b11, 32'h1}) begin n_err++; $display("FAIL lfsr_seed0: got %b%b/%h want 11/00000001", axl.tvalid, axl.tuser, axl.tdata); end
    tick;
    n_cmp++; if ({axl.tlast, axl.tdata} !== {1'b1, 32'h8020_0003}) begin n_err++; $display("FAIL lfsr_step: got %b/%h want 1/80200003", axl.tlast, axl.tdata); end
    tick;
    n_cmp++; if ({fdone_l, ready_l, busy_l} !== 3'b110) begin n_err++; $display("FAIL lfsr_done: got %b want 110", {fdone_l, ready_l, busy_l}); end
`ifdef GEN_ORIGIN_AXIS_STAT_EN
    n_cmp++; if (sb_l !== 32'd2 || ss_l !== 32'd0) begin n_err++; $display("FAIL lfsr_stats: got %0d/%0d want 2/0", sb_l, ss_l); end
`endif
  endtask

  task automatic test_abort_idle;
    abort = 1'b1;
    tick;
    tick;
    length = 32'd1; start = 32'd7; step = 32'd1; frames = 16'd2; gap = 16'd0;
    enable = 1'b1;
    tick;
    abort = 1'b0;
    n_cmp++; if ({ax.tvalid, ax.tlast, ax.tdata} !== {2'b11, 32'd7}) begin n_err++; $display("FAIL idle_abort_f1: got %b%b/%0d want 11/7", ax.tvalid, ax.tlast, ax.tdata); end
    tick;
    enable = 1'b0;
    n_cmp++; if ({ax.tvalid, ax.tuser, ax.tdata} !== {2'b11, 32'd7}) begin n_err++; $display("FAIL idle_abort_f2: got %b%b/%0d want 11/7", ax.tvalid, ax.tuser, ax.tdata); end
    tick;
    n_cmp++; if ({ax.tvalid, ready} !== 2'b01) begin n_err++; $display("FAIL idle_abort_end: tvalid/ready got %b want 01", {ax.tvalid, ready}); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_enable_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_aclken;
    start_frame(32'd6, 32'd0, 32'd1, 16'd1, 16'd0);
    tick;
    tick;
    aclken = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if ({ax.tvalid, ax.tdata, ax.tlast, busy, ready} !== {1'b1, 32'd2, 1'b0, 1'b1, 1'b0}) begin n_err++; $display("FAIL aclken_frozen[%0d]: got %b/%0d/%b/%b/%b want 1/2/0/1/0", i, ax.tvalid, ax.tdata, ax.tlast, busy, ready); end
    end
    enable = 1'b0;
    aclken = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if ({ax.tdata, ax.tlast} !== {32'd2 + 32'(j), j == 3}) begin n_err++; $display("FAIL aclken_resume[%0d]: got %0d/%b want %0d/%b", j, ax.tdata, ax.tlast, 2 + j, j == 3); end
      tick;
    end
    n_cmp++; if ({fdone, busy} !== 2'b10) begin n_err++; $display("FAIL aclken_done: got %b want 10", {fdone, busy}); end
`ifdef GEN_ORIGIN_AXIS_STAT_EN
    n_cmp++; if (sb !== 32'd6 || ss !== 32'd0) begin n_err++; $display("FAIL aclken_stats: got %0d/%0d want 6/0", sb, ss); end
`endif
  endtask

  task automatic test_rst_mid;
    start_frame(32'd6, 32'd0, 32'd1, 16'd1, 16'd0);
    tick;
    tick;
    n_cmp++; if (ax.tdata !== 32'd2) begin n_err++; $display("FAIL rst_pre: got %0d want 2", ax.tdata); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({ax.tvalid, ax.tlast, ax.tuser, busy, ready} !== 5'b00000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 00000", {ax.tvalid, ax.tlast, ax.tuser, busy, ready}); end
    n_cmp++; if (ax.tdata !== 32'd0) begin n_err++; $display("FAIL rst_mid_tdata: got %h want 0", ax.tdata); end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++; if ({ready, ax.tvalid, ax.tlast} !== 3'b100) begin n_err++; $display("FAIL rst_recover: got %b want 100", {ready, ax.tvalid, ax.tlast}); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; aclken = 1'b1; enable = 1'b0; enable_l = 1'b0; abort = 1'b0;
    length = '0; start = '0; step = '0; frames = '0; gap = '0;
    ax.tready = 1'b1;
    axl.tready = 1'b1;
    test_reset;
    test_range_gaps;
    test_single;
    test_stall;
    test_abort_cont;
    test_wrap;
    test_lfsr;
    test_abort_idle;
    test_aclken;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
